pueo_time_wb_initiator: RTL and testbench
=========================================

Name: pueo_time_wb_initiator

Overview:
- Wishbone classic initiator that drives the PUEO time register target (13-bit address, 32-bit data).
- Accepts single read/write commands from a local controller and returns one response per command with a status code.
- Also runs a "snapshot" command: three ordered reads SEC, LASTPPS, LLASTPPS, delivered as one coherent time triple.
- Every bus cycle has a timeout and a bounded retry count.

Parameters:
TIMEOUT_CYCLES, 255, cycles with cyc/stb high and no ack/err/rty before the cycle is aborted (1..65535).
RTY_LIMIT, 3, maximum re-issues after wb_rty_i per transfer (0 disables retry).
SEC_ADR, 13'h00C, address of the seconds register.
LASTPPS_ADR, 13'h010, address of the last-PPS register.
LLASTPPS_ADR, 13'h014, address of the last-last-PPS register.

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-high
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  command accepted when valid&&ready
cmd_snap_i  in  1  1 = snapshot command; the fields below are ignored
cmd_we_i  in  1  write when 1
cmd_adr_i  in  13  target address
cmd_dat_i  in  32  write data
cmd_sel_i  in  4  byte selects
rsp_valid_o  out  1  one-cycle response pulse
rsp_status_o  out  2  0 OK, 1 ERR, 2 RTY_EXHAUSTED, 3 TIMEOUT
rsp_dat_o  out  32  read data (0 for writes and failed transfers)
snap_valid_o  out  1  one-cycle pulse, set only when all three snapshot reads return OK
snap_sec_o  out  32  captured seconds
snap_last_o  out  32  captured last PPS
snap_llast_o  out  32  captured last-last PPS
wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone controls
wb_adr_o  out  13  address
wb_dat_o  out  32  write data
wb_sel_o  out  4  byte selects
wb_dat_i  in  32  read data
wb_ack_i, wb_err_i, wb_rty_i  in  1 each  terminations

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 except cmd_ready_o=1; snapshot registers and counters 0.
- States:
  - IDLE: cmd_ready_o=1. On accept, latch the command and go to BUS.
  - BUS: cyc=stb=1 with latched adr/dat/sel/we.
  - GAP: cyc=stb=0 for exactly one cycle.
  - RESP: emit the response.
- BUS termination, sampled each cycle:
  - Priority ack > err > rty > timeout.
  - ack: read data is registered; go to GAP.
  - err: status ERR; go to GAP.
  - rty: if retry count < RTY_LIMIT, increment it, go to GAP, then re-enter BUS with identical fields. Otherwise status RTY_EXHAUSTED.
  - Timeout counter reaches TIMEOUT_CYCLES: status TIMEOUT; go to GAP.
- cyc/stb drop the cycle after the termination is seen. The target therefore sees idle before any further request.
- GAP is mandatory between any two transfers, including retries and snapshot steps.
- Single command: GAP→RESP; rsp_valid_o pulses for 1 cycle; then IDLE.
  - Latency for a target that acks N cycles after stb: N+3 cycles from accept to rsp_valid_o.
- Snapshot sequence:
  - Reads are done in fixed order: SEC, then LASTPPS, then LLASTPPS, with we=0 and sel=4'hF.
  - SEC must be first: that read makes the target capture all three holding values.
  - A 2-bit index counter steps 0→1→2.
  - On the first non-OK status the sequence aborts: RESP reports that status, and snap_valid_o stays 0.
  - On success, snap_* registers update together, snap_valid_o and rsp_valid_o pulse in the same cycle, rsp_status_o=OK, and rsp_dat_o=SEC value.
  - snap_* outputs hold their last good values until the next successful snapshot.
- Signal timing:
  - Terminations arriving outside BUS are ignored.
  - The retry count and timeout counter clear at each new transfer; the retry count is not cleared on retry re-entry.
- Reset asserted mid-cycle: cyc/stb drop immediately (asynchronous). No response is emitted; the pending command is discarded.
- cmd_valid_i while not ready is held off. There is no queueing and nothing is dropped; the caller holds valid.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1). It saturates and does not wrap.

Decomposition:
- Package pueo_time_wb_pkg holds:
  - the status enum (OK/ERR/RTY_EXHAUSTED/TIMEOUT);
  - the state enum;
  - the register address constants (CTRL 0x00, TRIM 0x08, SEC 0x0C, LASTPPS 0x10, LLASTPPS 0x14), shared with the target core.
- No sub-module. The timeout counter is inline.

Test Plan:
- Write 0x0003_0001 to 0x000 with sel=4'hF, target acks after 2 cycles → cyc/stb high for 3 cycles; rsp_valid_o 5 cycles after accept; status 0, rsp_dat_o 0.
- Snapshot, target returns 0x0000_1234, 0x00AB_CDEF, 0x00AB_0000 → bus addresses issued in order 0x00C, 0x010, 0x014, with one idle cycle between each; snap_valid_o=1; snap_* match; rsp_dat_o=0x0000_1234.
- Read with the target asserting rty twice and then ack 0x55 (RTY_LIMIT=3) → 3 bus cycles with identical address; status OK; rsp_dat_o=0x55.
- Target never acks (TIMEOUT_CYCLES=255) → stb drops after 255 cycles; status 3; next command is accepted normally.
- Snapshot with err on the LASTPPS read → LLASTPPS is never addressed; status 1; snap_valid_o=0; snap_* unchanged.
- Assert wb_rst_i mid-BUS → cyc/stb go to 0 in the same cycle; no rsp_valid_o; cmd_ready_o=1 after release.

Source files
------------

// File: rtl/pueo_time_wb_pkg.sv
// rtl/pueo_time_wb_pkg.sv - shared types and register map for the PUEO time Wishbone initiator
package pueo_time_wb_pkg;

   typedef enum logic [1:0] {
      ST_OK            = 2'd0,
      ST_ERR           = 2'd1,
      ST_RTY_EXHAUSTED = 2'd2,
      ST_TIMEOUT       = 2'd3
   } status_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_GAP  = 2'd2,
      S_RESP = 2'd3
   } state_e;

   // Register map of the time target core
   localparam logic [12:0] REG_CTRL_ADR     = 13'h000;
   localparam logic [12:0] REG_TRIM_ADR     = 13'h008;
   localparam logic [12:0] REG_SEC_ADR      = 13'h00C;
   localparam logic [12:0] REG_LASTPPS_ADR  = 13'h010;
   localparam logic [12:0] REG_LLASTPPS_ADR = 13'h014;

endpackage

// File: rtl/pueo_time_wb_initiator.sv
// rtl/pueo_time_wb_initiator.sv - Wishbone classic initiator with retry, timeout and time snapshot
module pueo_time_wb_initiator
   import pueo_time_wb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned RTY_LIMIT      = 3,
   parameter logic [12:0] SEC_ADR        = REG_SEC_ADR,
   parameter logic [12:0] LASTPPS_ADR    = REG_LASTPPS_ADR,
   parameter logic [12:0] LLASTPPS_ADR   = REG_LLASTPPS_ADR
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_snap_i,
   input  logic        cmd_we_i,
   input  logic [12:0] cmd_adr_i,
   input  logic [31:0] cmd_dat_i,
   input  logic [3:0]  cmd_sel_i,
   output logic        rsp_valid_o,
   output logic [1:0]  rsp_status_o,
   output logic [31:0] rsp_dat_o,
   output logic        snap_valid_o,
   output logic [31:0] snap_sec_o,
   output logic [31:0] snap_last_o,
   output logic [31:0] snap_llast_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [12:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   input  logic        wb_rty_i
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RW = (RTY_LIMIT > 0) ? $clog2(RTY_LIMIT + 1) : 1;

   state_e      state, state_n;
   status_e     res_status, xfer_status;
   logic        done, retry, again, snap_mode, to_hit;
   logic [1:0]  idx;
   logic [RW-1:0] rty_cnt;
   logic [TW-1:0] to_cnt, to_cnt_n;
   logic        lat_we;
   logic [12:0] lat_adr;
   logic [31:0] lat_dat, rd_dat, tmp_sec, tmp_last;
   logic [3:0]  lat_sel;

   // Saturating count of BUS cycles including the current one
   assign to_cnt_n = (to_cnt == TW'(TIMEOUT_CYCLES)) ? to_cnt : to_cnt + TW'(1);
   assign to_hit   = (to_cnt_n == TW'(TIMEOUT_CYCLES));

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) state <= S_IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n     = state;
      done        = 1'b0;
      retry       = 1'b0;
      xfer_status = ST_OK;
      case (state)
         S_IDLE: if (cmd_valid_i) state_n = S_BUS;
         S_BUS: begin
            if (wb_ack_i) begin
               done = 1'b1;
            end else if (wb_err_i) begin
               done        = 1'b1;
               xfer_status = ST_ERR;
            end else if (wb_rty_i) begin
               if (32'(rty_cnt) < RTY_LIMIT) begin
                  retry = 1'b1;
               end else begin
                  done        = 1'b1;
                  xfer_status = ST_RTY_EXHAUSTED;
               end
            end else if (to_hit) begin
               done        = 1'b1;
               xfer_status = ST_TIMEOUT;
            end
            if (done || retry) state_n = S_GAP;
         end
         S_GAP:   state_n = again ? S_BUS : S_RESP;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         lat_we <= 1'b0; lat_adr <= '0; lat_dat <= '0; lat_sel <= '0;
         snap_mode <= 1'b0; idx <= '0; rty_cnt <= '0; to_cnt <= '0;
         again <= 1'b0; res_status <= ST_OK; rd_dat <= '0;
         tmp_sec <= '0; tmp_last <= '0;
         snap_sec_o <= '0; snap_last_o <= '0; snap_llast_o <= '0;
      end else begin
         case (state)
            S_IDLE: if (cmd_valid_i) begin
               snap_mode  <= cmd_snap_i;
               lat_we     <= cmd_snap_i ? 1'b0 : cmd_we_i;
               lat_adr    <= cmd_snap_i ? SEC_ADR : cmd_adr_i;
               lat_dat    <= cmd_snap_i ? 32'h0 : cmd_dat_i;
               lat_sel    <= cmd_snap_i ? 4'hF : cmd_sel_i;
               idx        <= '0;
               rty_cnt    <= '0;
               to_cnt     <= '0;
               again      <= 1'b0;
               res_status <= ST_OK;
               rd_dat     <= '0;
            end
            S_BUS: begin
               to_cnt <= to_cnt_n;
               if (retry) begin
                  rty_cnt <= rty_cnt + RW'(1);
                  again   <= 1'b1;
               end else if (done) begin
                  res_status <= xfer_status;
                  again      <= 1'b0;
                  if (xfer_status == ST_OK) begin
                     if (!snap_mode) begin
                        rd_dat <= lat_we ? 32'h0 : wb_dat_i;
                     end else begin
                        case (idx)
                           2'd0:    tmp_sec  <= wb_dat_i;
                           2'd1:    tmp_last <= wb_dat_i;
                           default: rd_dat   <= wb_dat_i;
                        endcase
                        // SEC read latches the target's holding registers; walk the rest in order
                        if (idx != 2'd2) begin
                           idx     <= idx + 2'd1;
                           lat_adr <= (idx == 2'd0) ? LASTPPS_ADR : LLASTPPS_ADR;
                           rty_cnt <= '0;
                           again   <= 1'b1;
                        end
                     end
                  end
               end
            end
            S_GAP: begin
               to_cnt <= '0;
               if (!again && snap_mode && res_status == ST_OK) begin
                  snap_sec_o   <= tmp_sec;
                  snap_last_o  <= tmp_last;
                  snap_llast_o <= rd_dat;
               end
            end
            default: ;
         endcase
      end
   end

   assign cmd_ready_o  = (state == S_IDLE);
   assign wb_cyc_o     = (state == S_BUS);
   assign wb_stb_o     = (state == S_BUS);
   assign wb_we_o      = (state == S_BUS) && lat_we;
   assign wb_adr_o     = lat_adr;
   assign wb_dat_o     = lat_dat;
   assign wb_sel_o     = lat_sel;
   assign rsp_valid_o  = (state == S_RESP);
   assign rsp_status_o = (state == S_RESP) ? res_status : 2'd0;
   assign rsp_dat_o    = (state == S_RESP && res_status == ST_OK) ? (snap_mode ? tmp_sec : rd_dat) : 32'h0;
   assign snap_valid_o = (state == S_RESP) && snap_mode && (res_status == ST_OK);

endmodule

// File: tb/tb_pueo_time_wb_initiator.sv
// tb/tb_pueo_time_wb_initiator.sv - scoreboard bench for the PUEO time Wishbone initiator
module tb_pueo_time_wb_initiator;

   logic        clk = 1'b0, rst = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_snap = 1'b0, cmd_we = 1'b0;
   logic [12:0] cmd_adr = '0;
   logic [31:0] cmd_dat = '0;
   logic [3:0]  cmd_sel = '0;
   logic        rsp_valid, snap_valid;
   logic [1:0]  rsp_status;
   logic [31:0] rsp_dat, snap_sec, snap_last, snap_llast;
   logic        cyc, stb, we;
   logic [12:0] adr;
   logic [31:0] wdat, rdat = '0;
   logic [3:0]  sel;
   logic        ack = 1'b0, err = 1'b0, rty = 1'b0;

   pueo_time_wb_initiator dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_snap_i(cmd_snap),
      .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
      .rsp_valid_o(rsp_valid), .rsp_status_o(rsp_status), .rsp_dat_o(rsp_dat),
      .snap_valid_o(snap_valid), .snap_sec_o(snap_sec), .snap_last_o(snap_last),
      .snap_llast_o(snap_llast),
      .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr), .wb_dat_o(wdat),
      .wb_sel_o(sel), .wb_dat_i(rdat), .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty)
   );

   always #5 clk = ~clk;

   int cnt = 0;
   always @(posedge clk) cnt++;

   int errors = 0, checks = 0;
   task automatic chk(string name, logic [36:0] act, logic [36:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard
   typedef struct {
      logic [1:0]  st;
      logic [31:0] dat;
      logic        sv;
      logic [31:0] sec, last, llast;
   } exp_t;
   exp_t sb[$];
   int rsp_cnt = 0, rsp_seen = 0;

   function automatic exp_t mk(logic [1:0] st, logic [31:0] dat, logic sv,
                               logic [31:0] sec, logic [31:0] last, logic [31:0] llast);
      exp_t e;
      e.st = st; e.dat = dat; e.sv = sv; e.sec = sec; e.last = last; e.llast = llast;
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst && snap_valid && !rsp_valid) chk("stray_snap_valid", 37'd1, 37'd0);
      if (!rst && rsp_valid) begin
         exp_t e;
         rsp_cnt = cnt;
         rsp_seen++;
         if (sb.size() == 0) begin
            chk("unexpected_rsp", 37'd1, 37'd0);
         end else begin
            e = sb.pop_front();
            chk("rsp_status", 37'(rsp_status), 37'(e.st));
            chk("rsp_dat", 37'(rsp_dat), 37'(e.dat));
            chk("snap_valid", 37'(snap_valid), 37'(e.sv));
            chk("snap_sec", 37'(snap_sec), 37'(e.sec));
            chk("snap_last", 37'(snap_last), 37'(e.last));
            chk("snap_llast", 37'(snap_llast), 37'(e.llast));
         end
      end
   end

   // target model: per bus cycle, terminate after wt cycles with kind 0 ack, 1 err, 2 rty, 3 none
   typedef struct { int wt; int kind; logic [31:0] dat; } beat_t;
   beat_t beats[$];
   beat_t cur;
   int bcnt = 0, gap = 0;
   bit in_bus = 0, first_cmd = 1;
   logic [12:0] adr_log[$];
   logic [36:0] ctl_log[$];
   int len_log[$], gap_log[$];

   always @(negedge clk) begin
      ack = 1'b0; err = 1'b0; rty = 1'b0; rdat = '0;
      if (cyc && stb) begin
         if (!in_bus) begin
            in_bus = 1; bcnt = 0;
            adr_log.push_back(adr);
            ctl_log.push_back({we, sel, wdat});
            if (!first_cmd) gap_log.push_back(gap);
            first_cmd = 0;
            if (beats.size() > 0) cur = beats.pop_front();
            else begin cur.wt = 0; cur.kind = 3; cur.dat = '0; end
         end
         if (cur.kind != 3 && bcnt == cur.wt) begin
            case (cur.kind)
               0: begin ack = 1'b1; rdat = cur.dat; end
               1: err = 1'b1;
               default: rty = 1'b1;
            endcase
         end
         bcnt++;
      end else begin
         if (in_bus) begin len_log.push_back(bcnt); in_bus = 0; gap = 0; end
         gap++;
      end
   end

   function automatic beat_t bt(int wt, int kind, logic [31:0] dat);
      beat_t b;
      b.wt = wt; b.kind = kind; b.dat = dat;
      return b;
   endfunction

   int acc_cnt = 0;
   task automatic issue(bit snap, bit w, logic [12:0] a, logic [31:0] d, logic [3:0] s);
      int n;
      adr_log.delete(); ctl_log.delete(); len_log.delete(); gap_log.delete();
      first_cmd = 1;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_snap = snap; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      if (!cmd_ready) chk("accept_timeout", 37'd0, 37'd1);
      acc_cnt = cnt;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (sb.size() > 0 && n < 1000) begin @(negedge clk); n++; end
      if (sb.size() != 0) begin chk("rsp_timeout", 37'd0, 37'd1); sb.delete(); end
      repeat (2) @(negedge clk);
   endtask

   logic [31:0] h_sec = '0, h_last = '0, h_llast = '0;
   int seen_before;

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_cmd_ready", 37'(cmd_ready), 37'd1);
      chk("reset_cyc_stb", 37'({cyc, stb}), 37'd0);
      chk("reset_rsp_valid", 37'(rsp_valid), 37'd0);
      chk("reset_snap_sec", 37'(snap_sec), 37'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // single write, ack on third bus cycle
      beats.push_back(bt(2, 0, 32'h0));
      sb.push_back(mk(2'd0, 32'h0, 1'b0, h_sec, h_last, h_llast));
      issue(0, 1, 13'h000, 32'h0003_0001, 4'hF);
      wait_rsp();
      chk("wr_stb_len", 37'(len_log.size() == 1 ? len_log[0] : -1), 37'd3);
      chk("wr_latency", 37'(rsp_cnt - acc_cnt), 37'd5);
      chk("wr_bus_ctl", ctl_log.size() == 1 ? ctl_log[0] : 37'h0, {1'b1, 4'hF, 32'h0003_0001});

      // snapshot success
      beats.push_back(bt(1, 0, 32'h0000_1234));
      beats.push_back(bt(0, 0, 32'h00AB_CDEF));
      beats.push_back(bt(3, 0, 32'h00AB_0000));
      h_sec = 32'h0000_1234; h_last = 32'h00AB_CDEF; h_llast = 32'h00AB_0000;
      sb.push_back(mk(2'd0, 32'h0000_1234, 1'b1, h_sec, h_last, h_llast));
      issue(1, 1, 13'h1FF, 32'hDEAD_BEEF, 4'h1);
      wait_rsp();
      chk("snap_n_cycles", 37'(adr_log.size()), 37'd3);
      if (adr_log.size() == 3) begin
         chk("snap_adr0", 37'(adr_log[0]), 37'h00C);
         chk("snap_adr1", 37'(adr_log[1]), 37'h010);
         chk("snap_adr2", 37'(adr_log[2]), 37'h014);
         chk("snap_ctl0", ctl_log[0], {1'b0, 4'hF, 32'h0});
      end
      for (int i = 0; i < gap_log.size(); i++) chk("snap_gap", 37'(gap_log[i]), 37'd1);

      // read with two retries then ack
      beats.push_back(bt(0, 2, 32'h0));
      beats.push_back(bt(1, 2, 32'h0));
      beats.push_back(bt(0, 0, 32'h0000_0055));
      sb.push_back(mk(2'd0, 32'h55, 1'b0, h_sec, h_last, h_llast));
      issue(0, 0, 13'h008, 32'h0, 4'hF);
      wait_rsp();
      chk("rty_n_cycles", 37'(adr_log.size()), 37'd3);
      for (int i = 0; i < adr_log.size(); i++) chk("rty_adr", 37'(adr_log[i]), 37'h008);
      for (int i = 0; i < gap_log.size(); i++) chk("rty_gap", 37'(gap_log[i]), 37'd1);

      // timeout
      beats.push_back(bt(0, 3, 32'h0));
      sb.push_back(mk(2'd3, 32'h0, 1'b0, h_sec, h_last, h_llast));
      issue(0, 0, 13'h00C, 32'h0, 4'hF);
      wait_rsp();
      chk("to_stb_len", 37'(len_log.size() == 1 ? len_log[0] : -1), 37'd255);

      // next command after timeout
      beats.push_back(bt(0, 0, 32'h0));
      sb.push_back(mk(2'd0, 32'h0, 1'b0, h_sec, h_last, h_llast));
      issue(0, 1, 13'h008, 32'h0000_0005, 4'h3);
      wait_rsp();
      chk("post_to_cycles", 37'(adr_log.size()), 37'd1);

      // snapshot aborted by err on LASTPPS
      beats.push_back(bt(0, 0, 32'h0000_1111));
      beats.push_back(bt(0, 1, 32'h0));
      sb.push_back(mk(2'd1, 32'h0, 1'b0, h_sec, h_last, h_llast));
      issue(1, 0, 13'h0, 32'h0, 4'h0);
      wait_rsp();
      chk("snap_err_cycles", 37'(adr_log.size()), 37'd2);

      // retry exhaustion
      repeat (4) beats.push_back(bt(0, 2, 32'h0));
      sb.push_back(mk(2'd2, 32'h0, 1'b0, h_sec, h_last, h_llast));
      issue(0, 0, 13'h010, 32'h0, 4'hF);
      wait_rsp();
      chk("rty_exh_cycles", 37'(adr_log.size()), 37'd4);

      // reset during BUS
      beats.push_back(bt(0, 3, 32'h0));
      seen_before = rsp_seen;
      issue(0, 0, 13'h014, 32'h0, 4'hF);
      repeat (3) @(negedge clk);
      chk("pre_rst_stb", 37'({cyc, stb}), 37'd3);
      #2 rst = 1'b1;
      #1 chk("rst_async_drop", 37'({cyc, stb}), 37'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("rst_cmd_ready", 37'(cmd_ready), 37'd1);
      chk("rst_no_rsp", 37'(rsp_seen - seen_before), 37'd0);
      chk("rst_snap_clear", 37'(snap_sec), 37'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
